// File: rtl/lsu_byte_sequencer_if.sv
// Core-side request/response and byte-wide memory port of the LSU byte sequencer.
// slave: the sequencer's view; master: the core plus memory driving it.
interface lsu_byte_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] m_addr;
  logic              m_re;
  logic              m_we;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;

  modport slave (
    input  req, we, func3, addr, wdata, m_rdata,
    output busy, done, err, rdata, m_addr, m_re, m_we, m_wdata
  );

  modport master (
    output req, we, func3, addr, wdata, m_rdata,
    input  busy, done, err, rdata, m_addr, m_re, m_we, m_wdata
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits one load/store into 1/2/4 byte beats on an 8-bit memory port; assembles loads.
// state  | meaning
// IDLE   | waiting for req;  ACCESS | one byte beat per cycle;  DONE | one-cycle completion
module lsu_byte_sequencer #(
  parameter int DATA_BASE = 128,
  parameter int ADDR_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  lsu_byte_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DATA_BASE);

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        beat;
  logic [1:0]        last_beat;
  logic              err_q;
  logic [31:0]       buf_q;
  logic [31:0]       rdata_q;

  logic              legal;
  logic [1:0]        last_n;
  logic [31:0]       word;
  logic [31:0]       load_ext;
  logic              access;

  // Width decode: last_n is the index of the final beat (N-1).
  always_comb begin
    legal  = 1'b0;
    last_n = 2'd0;
    case (bus.func3)
      3'b000: begin legal = 1'b1;     last_n = 2'd0; end
      3'b001: begin legal = 1'b1;     last_n = 2'd1; end
      3'b010: begin legal = 1'b1;     last_n = 2'd3; end
      3'b100: begin legal = ~bus.we;  last_n = 2'd0; end
      3'b101: begin legal = ~bus.we;  last_n = 2'd1; end
      default: begin legal = 1'b0;    last_n = 2'd0; end
    endcase
  end

  // The final byte is taken straight from m_rdata so rdata is ready in DONE.
  always_comb begin
    word = buf_q;
    word[8*beat +: 8] = bus.m_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{word[7]}}, word[7:0]};
      3'b001:  load_ext = {{16{word[15]}}, word[15:0]};
      3'b100:  load_ext = {24'd0, word[7:0]};
      3'b101:  load_ext = {16'd0, word[15:0]};
      default: load_ext = word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      base_q    <= '0;
      wdata_q   <= 32'd0;
      beat      <= 2'd0;
      last_beat <= 2'd0;
      err_q     <= 1'b0;
      buf_q     <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q      <= bus.we;
            f3_q      <= bus.func3;
            base_q    <= bus.addr + BASE;
            wdata_q   <= bus.wdata;
            beat      <= 2'd0;
            last_beat <= last_n;
            err_q     <= ~legal;
            buf_q     <= 32'd0;
            rdata_q   <= 32'd0;
            state     <= legal ? S_ACCESS : S_DONE;
          end
        end
        S_ACCESS: begin
          if (!we_q)
            buf_q[8*beat +: 8] <= bus.m_rdata;
          if (beat == last_beat) begin
            beat  <= 2'd0;
            state <= S_DONE;
            if (!we_q)
              rdata_q <= load_ext;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign access      = (state == S_ACCESS);
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.err     = (state == S_DONE) & err_q;
  assign bus.m_re    = access & ~we_q;
  assign bus.m_we    = access & we_q;
  assign bus.m_addr  = access ? base_q + ADDR_W'(beat) : '0;
  assign bus.m_wdata = access ? wdata_q[8*beat +: 8] : 8'd0;
  assign bus.rdata   = rdata_q;

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Initiator side of the unified byte-wide memory's data port.
- Sits between the core's MEM stage and the memory.
- Converts one load/store request (func3-encoded LB/LH/LW/LBU/LHU/SB/SH/SW) into 1, 2 or 4 sequential byte beats on an 8-bit memory port, then returns an assembled and extended load word.
- Data accesses are relocated into the upper data region by DATA_BASE.

Parameters:
- DATA_BASE, 128: byte offset added to every data address, modulo 256.
- ADDR_W, 8: byte address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  core request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; latched with req.
- func3  in  3  RISC-V width/sign code; latched with req.
- addr  in  ADDR_W  core byte address, unrelocated; latched with req.
- wdata  in  32  store data; latched with req.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal func3.
- rdata  out  32  load result; valid with done; held until the next acceptance.
- m_addr  out  ADDR_W  memory byte address.
- m_re  out  1  memory read strobe.
- m_we  out  1  memory write strobe; memory commits on the rising edge.
- m_wdata  out  8  write byte.
- m_rdata  in  8  read byte; combinational from m_addr in the same cycle.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; busy, done, err, m_re, m_we = 0.
  - m_addr, m_wdata = 0; rdata = 0; beat counter = 0.
- State IDLE:
  - Outputs deasserted.
  - On rising edge with req = 1, latch we/func3/addr/wdata.
  - Legal func3 -> ACCESS with beat = 0 and N set as follows:
    - Loads: 000 LB N=1; 001 LH N=2; 010 LW N=4; 100 LBU N=1; 101 LHU N=2.
    - Stores: 000 N=1; 001 N=2; 010 N=4.
  - Any other code (load 011/110/111; store 011–111) -> DONE with err = 1 and no memory strobes.
- State ACCESS (one beat per cycle):
  - m_addr = (addr + DATA_BASE + beat) mod 2^ADDR_W.
  - Load: m_re = 1, m_we = 0. Store: m_we = 1, m_re = 0.
  - m_wdata = wdata[8*beat+7 : 8*beat].
  - Load: on the rising edge, m_rdata is captured into byte lane `beat` of an internal buffer.
  - beat increments each edge; after beat = N-1 -> DONE.
- State DONE (exactly one cycle):
  - done = 1, busy = 1, no strobes.
  - rdata is valid for loads:
    - LB and LH sign-extend from bit 7 / bit 15.
    - LBU and LHU zero-extend.
    - LW is bytes {3,2,1,0}, little-endian.
  - Stores and err cases: rdata = 0.
  - Next state is IDLE.
- Latency:
  - req accepted at edge 0 -> beats occupy cycles 1..N -> done is high in cycle N+1.
  - Next request can be accepted at the edge ending the DONE cycle + 1 (i.e. while in IDLE).
  - err latency: done in cycle 1.
- Handshake:
  - req while busy = 1 is ignored; there is no queueing.
  - The core must hold req until it observes busy.
  - Inputs other than req are don't-care after acceptance.
- Alignment: no alignment restriction; misaligned halfwords and words are served byte-sequentially.
- Wrap: address increments wrap modulo 256, e.g. relocated 8'hFF then 8'h00.
- Reset during ACCESS:
  - Strobes drop combinationally-after-reset; no further beats.
  - Store bytes already committed on earlier edges remain in memory (non-atomic).
  - done is not pulsed.
- Strobe invariant: m_re and m_we are never both high.
- Strobe timing: both are zero outside ACCESS.

Test Plan:
- LW, addr = 0, memory[128..131] = 11,00,00,00 -> m_re high cycles 1–4 at m_addr 128,129,130,131 -> done in cycle 5, rdata = 32'd17, err = 0.
- LB then LBU, addr = 4, memory[132] = 8'h80 -> rdata = 32'hFFFFFF80 then 32'h00000080; each completes with done in cycle 2.
- SH, addr = 4, wdata = 32'h1234ABCD -> m_we beats (132, CD) then (133, AB). Follow with LHU addr 4 -> 32'h0000ABCD; LH addr 4 -> 32'hFFFFABCD.
- Load func3 = 3'b011 and store func3 = 3'b100 -> done and err in cycle 1, m_re = m_we = 0 throughout, rdata = 0.
- SW, addr = 8, wdata = 32'hDEADBEEF; assert rst mid-cycle 2 -> strobes and busy drop immediately, no done pulse; memory[136] = EF and memory[137..139] unchanged.
- LH, addr = 127 (relocated 255) with memory[255] = 34, memory[0] = 12 -> m_addr 255 then 0, rdata = 32'h00001234. A second req pulsed during busy is ignored, with no extra beats.
